tournament_chooser_ctrl: RTL and testbench

Chooser/meta-predictor controller for the tournament branch predictor. Holds a table of 2-bit choice counters indexed by PC, picks between the gshare (global) and two-level adaptive (local) predictions, and registers the final taken/not-taken. Resolved-branch updates are buffered in a small FIFO and drained one per cycle into the choice table. A post-reset INIT sequence clears the table before predictions are accepted.

---
 rtl/tournament_chooser_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_tournament_chooser_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tournament_chooser_ctrl.sv
// tournament_chooser_ctrl
//
// Chooser (meta-predictor) for the tournament branch predictor. A table of
// 2-bit choice counters, indexed by pc[IDX_W+1:2], selects between the gshare
// (global) and two-level adaptive (local) predictions. Resolved-branch updates
// are queued in a small FIFO and drained one per cycle into the table. After
// reset an INIT sequence writes CTR_INIT into every entry before any request
// or update is accepted.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   pred_valid/pred_ready prediction request handshake
//   pred_pc               PC of the request
//   global_pred           gshare prediction for pred_pc
//   local_pred            local prediction for pred_pc
//   pred_out_valid        result valid, one cycle after an accepted request
//   pred_taken            final taken/not-taken
//   pred_use_global       1 = global component chosen
//   upd_valid/upd_ready   resolved-branch update handshake
//   upd_pc                PC of the resolved branch
//   upd_global_pred       what gshare predicted
//   upd_local_pred        what the local predictor predicted
//   upd_taken             actual outcome
//   init_done             high once the table has been initialised
//
// Optional feature (macro TOURN_CHOOSER_STATS_EN):
//   stat_mispredict_cnt   16-bit saturating count of drained updates whose
//                         currently chosen component mispredicted

module tournament_chooser_ctrl #(
    parameter int         PC_W       = 32,
    parameter int         IDX_W      = 6,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] CTR_INIT   = 2'b01
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            pred_valid,
    input  logic [PC_W-1:0] pred_pc,
    input  logic            global_pred,
    input  logic            local_pred,
    output logic            pred_ready,
    output logic            pred_out_valid,
    output logic            pred_taken,
    output logic            pred_use_global,
    input  logic            upd_valid,
    output logic            upd_ready,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_global_pred,
    input  logic            upd_local_pred,
    input  logic            upd_taken,
    output logic            init_done
`ifdef TOURN_CHOOSER_STATS_EN
    ,
    output logic [15:0]     stat_mispredict_cnt
`endif
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int UPD_W   = IDX_W + 3;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] init_idx;
    logic             init_last;
    logic [1:0]       ctr_table [ENTRIES];

    logic [UPD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             pred_accept;

    logic [IDX_W-1:0] pred_idx;
    logic [1:0]       pred_ctr;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] head_idx;
    logic             head_gpred;
    logic             head_lpred;
    logic             head_taken;
    logic             g_ok;
    logic             l_ok;
    logic [1:0]       head_ctr;
    logic [1:0]       head_ctr_next;
    logic             unused_pc_bits;

    // Word-aligned PCs: bits [1:0] and everything above the index are ignored.
    assign pred_idx       = pred_pc[IDX_W+1:2];
    assign upd_idx        = upd_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                              upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

    assign init_last   = (init_idx == IDX_W'(ENTRIES - 1));
    assign fifo_full   = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty  = (fifo_count == '0);
    assign pred_accept = pred_valid & pred_ready;
    assign push        = upd_valid & upd_ready;
    assign pop         = (state == ST_RUN) & ~fifo_empty;

    assign {head_idx, head_gpred, head_lpred, head_taken} = fifo_mem[rd_ptr];
    assign g_ok     = (head_gpred == head_taken);
    assign l_ok     = (head_lpred == head_taken);
    assign head_ctr = ctr_table[head_idx];
    assign pred_ctr = ctr_table[pred_idx];

    // State register; reset restarts INIT from any state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs. Nothing is accepted until the whole
    // table has been written during INIT.
    always_comb begin
        state_next = state;
        pred_ready = 1'b0;
        upd_ready  = 1'b0;
        init_done  = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_last) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                pred_ready = 1'b1;
                upd_ready  = ~fifo_full;
                init_done  = 1'b1;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // Saturating choice-counter update: move towards whichever component was
    // uniquely right; leave it alone when both or neither were right.
    always_comb begin
        head_ctr_next = head_ctr;
        if (g_ok && !l_ok && head_ctr != 2'd3) begin
            head_ctr_next = head_ctr + 2'd1;
        end else if (l_ok && !g_ok && head_ctr != 2'd0) begin
            head_ctr_next = head_ctr - 2'd1;
        end
    end

    // INIT walks the table index from 0 upward, one entry per cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            init_idx <= '0;
        end else if (state == ST_INIT) begin
            init_idx <= init_idx + 1'b1;
        end
    end

    // Single table write port: INIT fill or the drained FIFO head. A write in
    // the reset cycle is suppressed so a flushed update never lands.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                ctr_table[init_idx] <= CTR_INIT;
            end else if (pop) begin
                ctr_table[head_idx] <= head_ctr_next;
            end
        end
    end

    // FIFO storage keeps only the table index plus the three outcome bits.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {upd_idx, upd_global_pred, upd_local_pred, upd_taken};
        end
    end

    // FIFO pointers and occupancy; power-of-two depth makes the wrap free.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Registered prediction. The table read happens before any same-cycle
    // drain write lands, so a colliding update is seen one cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            pred_out_valid  <= 1'b0;
            pred_taken      <= 1'b0;
            pred_use_global <= 1'b0;
        end else begin
            pred_out_valid <= pred_accept;
            if (pred_accept) begin
                pred_use_global <= pred_ctr[1];
                pred_taken      <= pred_ctr[1] ? global_pred : local_pred;
            end
        end
    end

`ifdef TOURN_CHOOSER_STATS_EN
    logic chosen_wrong;

    // Judge the drained update against the component chosen before the write.
    assign chosen_wrong = head_ctr[1] ? ~g_ok : ~l_ok;

    // Saturating mispredict counter, cleared by reset and while initialising.
    always_ff @(posedge clock) begin
        if (reset || state == ST_INIT) begin
            stat_mispredict_cnt <= '0;
        end else if (pop && chosen_wrong && stat_mispredict_cnt != 16'hFFFF) begin
            stat_mispredict_cnt <= stat_mispredict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tournament_chooser_ctrl.sv
// tb_tournament_chooser_ctrl
//
// Directed bench for tournament_chooser_ctrl with a small reference model of
// the choice table. Expected predictions are queued when a request is driven
// and popped when pred_out_valid comes back. Build with
// TOURN_CHOOSER_STATS_EN defined to also check stat_mispredict_cnt.

module tb_tournament_chooser_ctrl;

    localparam int         PC_W     = 32;
    localparam int         IDX_W    = 6;
    localparam int         ENTRIES  = 1 << IDX_W;
    localparam logic [1:0] CTR_INIT = 2'b01;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            pred_valid = 1'b0;
    logic [PC_W-1:0] pred_pc = '0;
    logic            global_pred = 1'b0;
    logic            local_pred = 1'b0;
    logic            pred_ready;
    logic            pred_out_valid;
    logic            pred_taken;
    logic            pred_use_global;
    logic            upd_valid = 1'b0;
    logic            upd_ready;
    logic [PC_W-1:0] upd_pc = '0;
    logic            upd_global_pred = 1'b0;
    logic            upd_local_pred = 1'b0;
    logic            upd_taken = 1'b0;
    logic            init_done;
`ifdef TOURN_CHOOSER_STATS_EN
    logic [15:0]     stat_mispredict_cnt;
    logic [15:0]     m_stat = '0;
`endif

    always #5 clock = ~clock;

    tournament_chooser_ctrl #(
        .PC_W      (PC_W),
        .IDX_W     (IDX_W),
        .FIFO_DEPTH(4),
        .CTR_INIT  (CTR_INIT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .global_pred    (global_pred),
        .local_pred     (local_pred),
        .pred_ready     (pred_ready),
        .pred_out_valid (pred_out_valid),
        .pred_taken     (pred_taken),
        .pred_use_global(pred_use_global),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_pc         (upd_pc),
        .upd_global_pred(upd_global_pred),
        .upd_local_pred (upd_local_pred),
        .upd_taken      (upd_taken),
        .init_done      (init_done)
`ifdef TOURN_CHOOSER_STATS_EN
        ,
        .stat_mispredict_cnt(stat_mispredict_cnt)
`endif
    );

    typedef struct packed {
        logic use_global;
        logic taken;
    } pred_exp_t;

    pred_exp_t        exp_q[$];
    logic [1:0]       m_ctr [ENTRIES];
    logic             m_run = 1'b0;
    int               init_left = 0;
    logic             def_valid = 1'b0;
    logic [IDX_W-1:0] def_idx = '0;
    logic             def_g = 1'b0;
    logic             def_l = 1'b0;
    logic             def_t = 1'b0;
    int               pass_cnt = 0;
    int               fail_cnt = 0;
    int               total_cnt = 0;

    // One comparison: counts it, and reports tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference counter rule, applied at the moment the drain writes.
    task automatic applyModelUpdate(input logic [IDX_W-1:0] idx, input logic g,
                                    input logic l, input logic t);
        logic g_ok;
        logic l_ok;
        g_ok = (g == t);
        l_ok = (l == t);
`ifdef TOURN_CHOOSER_STATS_EN
        if (((m_ctr[idx] >= 2'd2) ? !g_ok : !l_ok) && m_stat != 16'hFFFF) begin
            m_stat = m_stat + 16'd1;
        end
`endif
        if (g_ok && !l_ok && m_ctr[idx] != 2'd3) begin
            m_ctr[idx] = m_ctr[idx] + 2'd1;
        end else if (l_ok && !g_ok && m_ctr[idx] != 2'd0) begin
            m_ctr[idx] = m_ctr[idx] - 2'd1;
        end
    endtask

    // Advance one clock, then sample everything #1 after the edge.
    task automatic tick();
        pred_exp_t e;
        @(posedge clock);
        #1;
        if (!m_run) begin
            init_left--;
            if (init_left == 0) begin
                m_run = 1'b1;
                for (int i = 0; i < ENTRIES; i++) begin
                    m_ctr[i] = CTR_INIT;
                end
            end
        end
        checkOutput("init_done", init_done, m_run);
        checkOutput("pred_ready", pred_ready, m_run);
        checkOutput("upd_ready", upd_ready, m_run);
        checkOutput("pred_out_valid", pred_out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (pred_out_valid === 1'b1) begin
                checkOutput("pred_use_global", pred_use_global, e.use_global);
                checkOutput("pred_taken", pred_taken, e.taken);
            end
        end
`ifdef TOURN_CHOOSER_STATS_EN
        checkOutput("stat_mispredict_cnt", stat_mispredict_cnt, m_stat);
`endif
    endtask

    // Drive one cycle of inputs and advance. An update pushed while the FIFO
    // is otherwise empty is written at the end of the following cycle, and a
    // prediction in that cycle still sees the old counter value.
    task automatic applyStimulus(input logic pv, input logic [31:0] ppc,
                                 input logic gp, input logic lp,
                                 input logic uv, input logic [31:0] upc,
                                 input logic ug, input logic ul, input logic ut);
        pred_exp_t        e;
        logic [IDX_W-1:0] idx;
        pred_valid      = pv;
        pred_pc         = ppc;
        global_pred     = gp;
        local_pred      = lp;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_global_pred = ug;
        upd_local_pred  = ul;
        upd_taken       = ut;
        if (pv && m_run) begin
            idx          = ppc[IDX_W+1:2];
            e.use_global = (m_ctr[idx] >= 2'd2);
            e.taken      = e.use_global ? gp : lp;
            exp_q.push_back(e);
        end
        if (def_valid) begin
            applyModelUpdate(def_idx, def_g, def_l, def_t);
            def_valid = 1'b0;
        end
        if (uv && m_run) begin
            def_valid = 1'b1;
            def_idx   = upc[IDX_W+1:2];
            def_g     = ug;
            def_l     = ul;
            def_t     = ut;
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One-cycle synchronous reset; everything queued is discarded.
    task automatic doReset();
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        reset      = 1'b1;
        exp_q.delete();
        def_valid  = 1'b0;
        m_run      = 1'b0;
        init_left  = ENTRIES + 1;
`ifdef TOURN_CHOOSER_STATS_EN
        m_stat     = '0;
`endif
        tick();
        checkOutput("reset_pred_taken", pred_taken, 1'b0);
        checkOutput("reset_pred_use_global", pred_use_global, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        doReset();

        // Offer requests and updates all through INIT; none may be accepted.
        for (int i = 0; i < ENTRIES; i++) begin
            applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1);
        end

        // Fresh table prefers local.
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Two global-wins updates push the counter to 3.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1);
        idle(2);
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // A third one saturates at 3, then one local-wins step keeps it global.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1);
        idle(2);
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b1);
        idle(2);
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Prediction collides with the drain write to the same entry.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Five back-to-back updates to one entry; order matters with saturation.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b1);
        idle(2);
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Mixed concurrent traffic over a few entries.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 32'h80 + 32'($urandom_range(0, 3)) * 4,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 32'h80 + 32'($urandom_range(0, 3)) * 4,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        end
        idle(2);

        // Reset in the middle of INIT restarts the full sequence.
        doReset();
        idle(30);
        doReset();
        idle(ENTRIES);

        // Reset with updates still queued: they must never reach the table.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h104, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h108, 1'b1, 1'b0, 1'b1);
        doReset();
        idle(ENTRIES + 3);
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

`ifdef TOURN_CHOOSER_STATS_EN
        // Three drains where the chosen local component was wrong.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h208, 1'b0, 1'b0, 1'b1);
        idle(2);
        checkOutput("stat_after_three", stat_mispredict_cnt, 16'd3);
        doReset();
        checkOutput("stat_after_reset", stat_mispredict_cnt, 16'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
